// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access-size codes,
// FSM state type and the alignment helpers used by the request path.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        StIdle,
        StResp
    } state_t;

    // Encoding 11 behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_HALF: return {offset[1], 1'b0};
            SZ_WORD: return 2'b00;
            default: return offset;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load lane select with sign/zero extension, and store
// data replication with byte enables. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data,
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [31:0] st_word,
    output logic [3:0]  st_be
);

    logic [31:0] shifted;

    always_comb begin
        shifted = ld_word >> {ld_offset, 3'b000};
        ld_data = ld_word;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default: ld_data = ld_word;
        endcase
    end

    // Replicate the right-aligned data across lanes; the enables pick the target lanes.
    always_comb begin
        st_word = st_data;
        st_be   = 4'b1111;
        case (st_size)
            SZ_BYTE: begin
                st_word = {4{st_data[7:0]}};
                st_be   = 4'b0001 << st_offset;
            end
            SZ_HALF: begin
                st_word = {2{st_data[15:0]}};
                st_be   = 4'b0011 << st_offset;
            end
            default: begin
                st_word = st_data;
                st_be   = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-cycle-latency data memory responder with valid/ready request and response.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter bit          INIT_ZERO   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall_req
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    state_t state_q, state_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [IdxW-1:0] idx;
    logic [1:0]    size_n;
    logic [1:0]    off_n;
    logic          err_n;
    logic          accept;
    logic [31:0]   st_word;
    logic [3:0]    st_be;

    logic [31:0]   word_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;
    logic          uns_q;
    logic          err_q;

    // Zero fill at time 0 relies on the simulator's initial-value setting.
    logic unused_init_zero;
    logic unused_addr_hi;
    assign unused_init_zero = INIT_ZERO;
    assign unused_addr_hi   = ^req_addr[31:IdxW+2];

    assign idx    = req_addr[IdxW+1:2];
    assign size_n = norm_size(req_size);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign err_n = misaligned(size_n, req_addr[1:0]);
    assign off_n = req_addr[1:0];
`else
    assign err_n = 1'b0;
    assign off_n = align_offset(size_n, req_addr[1:0]);
`endif

    assign req_ready = (state_q == StIdle) | ((state_q == StResp) & rsp_ready);
    assign accept    = req_valid & req_ready;
    assign stall_req = req_valid & ~req_ready;
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = StResp;
            StResp: if (rsp_ready && !accept) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Stores and faulting accesses capture a zero word so the response reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            size_q <= SZ_WORD;
            off_q  <= 2'b00;
            uns_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            word_q <= (req_we || err_n) ? '0 : mem[idx];
            size_q <= size_n;
            off_q  <= off_n;
            uns_q  <= req_unsigned;
            err_q  <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !err_n) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem[idx][8*i +: 8] <= st_word[8*i +: 8];
            end
        end
    end

    dmem_lane_align u_lane_align (
        .ld_size     (size_q),
        .ld_offset   (off_q),
        .ld_unsigned (uns_q),
        .ld_word     (word_q),
        .ld_data     (rsp_rdata),
        .st_size     (size_n),
        .st_offset   (off_n),
        .st_data     (req_wdata),
        .st_word     (st_word),
        .st_be       (st_be)
    );

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit array words (power of two).
REQ-002 SHALL have parameter INIT_ZERO, default 1, meaning the array is zeroed at time 0 in simulation only.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  the request is present.
REQ-006 SHALL have port req_ready  out  1  the responder accepts the request this cycle.
REQ-007 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  in  32  the byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-011 SHALL have port req_unsigned  in  1  zero-extends a load (LBU/LHU) instead of sign-extending it.
REQ-012 SHALL have port rsp_valid  out  1  the response is present.
REQ-013 SHALL have port rsp_ready  in  1  the requester consumes the response.
REQ-014 SHALL have port rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores.
REQ-015 SHALL have port rsp_err  out  1  the access was misaligned.
REQ-016 SHALL have port stall_req  out  1  equal to req_valid & ~req_ready, for pipeline freeze.

Function
REQ-017 SHALL use the state machine IDLE and RESP; reset state IDLE.
REQ-018 SHALL define accept as req_valid & req_ready at a rising edge.
REQ-019 SHALL drive req_ready = (state==IDLE) | (state==RESP & rsp_ready).
REQ-020 SHALL, on accept, move to RESP; rsp_valid is high in the cycle after accept (1-cycle latency).
REQ-021 SHALL retire a response on rsp_valid & rsp_ready: return to IDLE, or stay in RESP with new data if an accept occurs at the same edge (1 access/cycle sustained).
REQ-022 SHALL hold rsp_rdata and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-023 SHALL form the word index from req_addr bits starting at 2, using log2(DEPTH_WORDS) bits; higher bits are ignored (wrap-around).
REQ-024 SHALL commit a store to the array at the accept edge, using byte enables derived from size and addr[1:0]; a byte store writes one lane, a half store two lanes, a word store four.
REQ-025 SHALL register load data at the accept edge, then select the lane by addr[1:0] and extend it per req_unsigned, with the size and offset captured at accept.
REQ-026 SHALL make a load at the edge after a store to the same word return the new data (no read-during-write hazard across cycles).
REQ-027 SHALL NOT reset rsp_rdata between responses; it is updated only on accept.

Reset
REQ-028 SHALL, while reset is asserted, immediately force state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-029 SHALL drop a pending response on reset mid-operation; a store already committed remains in the array.
REQ-030 SHALL NOT reset array contents.

Configuration
REQ-031 SHALL recognise macro DMEM_MISALIGN_CHECK_EN.
REQ-032 SHALL, when DMEM_MISALIGN_CHECK_EN is defined, flag a half access with addr[0]=1 or a word access with addr[1:0]!=0 as follows: no array write, rsp_err=1, rsp_rdata=0, same latency.
REQ-033 SHALL, when DMEM_MISALIGN_CHECK_EN is undefined, tie rsp_err to 0 and ignore the offending low address bits (access forced to natural alignment).

Structure
REQ-034 SHALL place the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the state enum in shared package dmem_pkg.
REQ-035 SHALL implement load lane-select/extension and store byte-enable/data replication in one combinational sub-module, dmem_lane_align.

Verification
REQ-036 SHALL cover: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_rdata=0xDEADBEEF one cycle after accept.
REQ-037 SHALL cover: store byte 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-038 SHALL cover: back-to-back loads with rsp_ready=1 -> req_ready stays 1 and one response per cycle; holding rsp_ready=0 for 3 cycles -> rsp_rdata stable, stall_req=1.
REQ-039 SHALL cover: LW @0x402 with DEPTH_WORDS=256 and the macro defined -> rsp_err=1, rsp_rdata=0, memory unchanged; without the macro -> data of word 0 (wrap, aligned), rsp_err=0.
REQ-040 SHALL cover: reset asserted while rsp_valid=1 -> rsp_valid=0 immediately; a subsequent load shows the pre-reset store intact.
